// File: rtl/tdc_capture_decoder_if.sv
// tdc_capture_decoder_if: tap/start inputs and measurement result bundle for the TDC decoder.
interface tdc_capture_decoder_if #(parameter int TAPS = 64);
  localparam int CW = $clog2(TAPS + 1);
  logic [TAPS-1:0] tap;
  logic start;
  logic busy;
  logic valid;
  logic [CW-1:0] code;
  logic err;
  logic ovf;
  modport master(output tap, start, input busy, valid, code, err, ovf);
  modport slave(input tap, start, output busy, valid, code, err, ovf);
endinterface

// File: rtl/tdc_capture_decoder.sv
// tdc_capture_decoder: synchronises delay-line taps, decodes edge position and averages 2^AVG_LOG2 samples.
module tdc_capture_decoder #(
  parameter int TAPS = 64,
  parameter int SYNC_STAGES = 2,
  parameter int AVG_LOG2 = 4
) (
  input logic clk,
  input logic rst,
  tdc_capture_decoder_if.slave bus
);
  localparam int CW = $clog2(TAPS + 1);
  localparam int AW = CW + AVG_LOG2;
  localparam int NS = 1 << AVG_LOG2;
  localparam int KW = AVG_LOG2 + $clog2(SYNC_STAGES + 2) + 1;
  typedef enum logic [1:0] {IDLE, SETTLE, ACC, DONE} state_t;
  state_t state, state_d;
  logic [TAPS-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0] dec_code, code_q, code_o;
  logic dec_bub, dec_ovf, found, bub_q, ovf_q;
  logic [KW-1:0] cnt;
  logic [AW-1:0] acc, acc_nxt;
  logic err_acc, ovf_acc, err_o, ovf_o, valid_o;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= bus.tap;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end
  // code = index of the first zero tap; any one above it is a bubble
  always_comb begin
    dec_code = CW'(TAPS);
    dec_bub = 1'b0;
    found = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      if (!found && !sync_q[SYNC_STAGES-1][i]) begin
        dec_code = CW'(i);
        found = 1'b1;
      end else if (found && sync_q[SYNC_STAGES-1][i]) dec_bub = 1'b1;
    end
    dec_ovf = &sync_q[SYNC_STAGES-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q <= '0;
      bub_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      code_q <= dec_code;
      bub_q <= dec_bub;
      ovf_q <= dec_ovf;
    end
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_d;
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: state_d = bus.start ? SETTLE : IDLE;
      SETTLE: state_d = (cnt == KW'(SYNC_STAGES)) ? ACC : SETTLE;
      ACC: state_d = (cnt == KW'(NS - 1)) ? DONE : ACC;
      default: state_d = IDLE;
    endcase
  end
  assign acc_nxt = acc + AW'(code_q);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      err_acc <= 1'b0;
      ovf_acc <= 1'b0;
      code_o <= '0;
      err_o <= 1'b0;
      ovf_o <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      cnt <= (state_d != state) ? '0 : cnt + 1'b1;
      valid_o <= state_d == DONE;
      if (state == IDLE) begin
        acc <= '0;
        err_acc <= 1'b0;
        ovf_acc <= 1'b0;
      end
      if (state == ACC) begin
        acc <= acc_nxt;
        err_acc <= err_acc | bub_q;
        ovf_acc <= ovf_acc | ovf_q;
      end
      // results latch on entry to DONE so they coincide with the VALID strobe
      if (state == ACC && state_d == DONE) begin
        code_o <= acc_nxt[AW-1:AVG_LOG2];
        err_o <= err_acc | bub_q;
        ovf_o <= ovf_acc | ovf_q;
      end
    end
  end
  assign bus.busy = (state == SETTLE) || (state == ACC);
  assign bus.valid = valid_o;
  assign bus.code = code_o;
  assign bus.err = err_o;
  assign bus.ovf = ovf_o;
endmodule
